// File: rtl/sram_chip_pkg.sv
// Shared widths and read-pipe entry type for the SRAM chip model.
// Imported by sram_rd_pipe and sram_chip_model.
package sram_chip_pkg;

    localparam int SRAM_DQ_W        = 16;
    localparam int SRAM_ADDR_W      = 18;
    localparam int SRAM_MAX_LATENCY = 3;

    typedef struct packed {
        logic                   valid;
        logic [SRAM_ADDR_W-1:0] addr;
    } rd_pipe_ent_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read access-latency pipe: data_ok once the read address has been held
// READ_LATENCY cycles; lat_err flags a read address abandoned too early.
module sram_rd_pipe
    import sram_chip_pkg::*;
#(
    parameter int READ_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdc,
    input  logic [SRAM_ADDR_W-1:0] addr,
    output logic                   data_ok,
    output logic                   lat_err
);

    if (READ_LATENCY == 0) begin : g_nolat

        logic unused_pipe;
        assign unused_pipe = ^{clk, rst, addr};
        assign data_ok     = rdc;
        assign lat_err     = 1'b0;

    end else begin : g_lat

        localparam logic [1:0] LAT = 2'(READ_LATENCY);

        rd_pipe_ent_t pipe_q [READ_LATENCY];
        rd_pipe_ent_t pipe_d [READ_LATENCY];
        logic [1:0]   hold_q;
        logic [1:0]   hold_d;
        logic         lat_err_q;
        logic         lat_err_d;
        logic         ok;
        logic         addr_chg;

        // Shift pipe, track how long the current read address has been held.
        always_comb begin
            pipe_d[0].valid = rdc;
            pipe_d[0].addr  = addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            addr_chg = pipe_q[0].valid && (pipe_q[0].addr != addr);
            hold_d   = 2'd0;
            if (rdc) begin
                if (pipe_q[0].valid && !addr_chg) begin
                    hold_d = (hold_q < LAT) ? hold_q + 2'd1 : LAT;
                end else begin
                    hold_d = 2'd1;
                end
            end
            lat_err_d = lat_err_q | (rdc && addr_chg && (hold_q < LAT));
            ok        = rdc;
            for (int i = 0; i < READ_LATENCY; i++) begin
                if (!pipe_q[i].valid || (pipe_q[i].addr != addr)) begin
                    ok = 1'b0;
                end
            end
        end

        // Pipe and sticky error registers; reset drops all valid bits.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < READ_LATENCY; i++) begin
                    pipe_q[i] <= '0;
                end
                hold_q    <= 2'd0;
                lat_err_q <= 1'b0;
            end else begin
                for (int i = 0; i < READ_LATENCY; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
                hold_q    <= hold_d;
                lat_err_q <= lat_err_d;
            end
        end

        assign data_ok = ok;
        assign lat_err = lat_err_q;

    end

endmodule

// File: rtl/sram_chip_model.sv
// Clocked model of a 256K x 16 async SRAM with byte lanes, read latency
// and access counters. Define SRAM_CHIP_MODEL_TRACE_EN for access tracing.
module sram_chip_model
    import sram_chip_pkg::*;
#(
    parameter int DEPTH        = 262144,
    parameter int READ_LATENCY = 0,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    input  logic                   SRAM_UB_N,
    input  logic                   SRAM_LB_N,
    input  logic                   SRAM_WE_N,
    input  logic                   SRAM_CE_N,
    input  logic                   SRAM_OE_N,
    output logic [CNT_W-1:0]       rd_cnt,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic                   lat_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Contents start at zero and survive rst, like the real part.
    logic [SRAM_DQ_W-1:0] mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]     idx;
    logic                 rdc;
    logic                 wr_en;
    logic                 lanes_any;
    logic                 data_ok;
    logic [SRAM_DQ_W-1:0] rd_word;
    logic [CNT_W-1:0]     rd_cnt_q;
    logic [CNT_W-1:0]     rd_cnt_d;
    logic [CNT_W-1:0]     wr_cnt_q;
    logic [CNT_W-1:0]     wr_cnt_d;

    assign idx       = SRAM_ADDR[IDX_W-1:0];
    assign rdc       = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
    assign wr_en     = !SRAM_CE_N && !SRAM_WE_N;
    assign lanes_any = !SRAM_UB_N || !SRAM_LB_N;

    sram_rd_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .rdc     (rdc),
        .addr    (SRAM_ADDR),
        .data_ok (data_ok),
        .lat_err (lat_err)
    );

    // Byte-lane masked write; also commits during the reset cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !SRAM_UB_N) begin
            mem[idx][15:8] <= SRAM_DQ[15:8];
        end
        if (wr_en && !SRAM_LB_N) begin
            mem[idx][7:0] <= SRAM_DQ[7:0];
        end
    end

    // Saturating access counters.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rdc && !(&rd_cnt_q)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (wr_en && lanes_any && !(&wr_cnt_q)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign rd_word = data_ok ? mem[idx] : 16'hxxxx;

    assign SRAM_DQ[15:8] = (rdc && !SRAM_UB_N) ? rd_word[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (rdc && !SRAM_LB_N) ? rd_word[7:0]  : 8'hzz;

`ifdef SRAM_CHIP_MODEL_TRACE_EN
    logic [SRAM_ADDR_W-1:0] trc_addr_q;
    logic                   trc_rdc_q;

    // Log committed writes and each new read address.
    always @(posedge clk) begin
        if (wr_en && lanes_any) begin
            $display("%0t sram wr idx=%h data=%h mask=%b",
                     $time, idx, SRAM_DQ, {!SRAM_UB_N, !SRAM_LB_N});
        end
        if (rdc && (!trc_rdc_q || (trc_addr_q != SRAM_ADDR))) begin
            $display("%0t sram rd idx=%h data=%h", $time, idx, mem[idx]);
        end
        trc_rdc_q  <= rdc;
        trc_addr_q <= SRAM_ADDR;
    end
`endif

endmodule

// File: tb/tb_sram_chip_model.sv
// Scoreboard bench for sram_chip_model: three instances cover L=0,
// L=2 and a 16-word / 2-bit-counter build. DQ buses carry pullups.
module tb_sram_chip_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, oe_n;
    logic [2:0]  ce_n;
    logic        tb_oe;
    logic [15:0] tb_dq;

    wire [15:0] dq0, dq1, dq2;
    assign dq0 = tb_oe ? tb_dq : 16'hzzzz;
    assign dq1 = tb_oe ? tb_dq : 16'hzzzz;
    assign dq2 = tb_oe ? tb_dq : 16'hzzzz;

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (dq0[g]);
        pullup (dq1[g]);
        pullup (dq2[g]);
    end

    logic [31:0] rd0, wr0, rd1, wr1;
    logic [1:0]  rd2, wr2;
    logic        lat0, lat1, lat2;

    sram_chip_model #(.DEPTH(262144), .READ_LATENCY(0), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n),
        .rd_cnt(rd0), .wr_cnt(wr0), .lat_err(lat0)
    );

    sram_chip_model #(.DEPTH(1024), .READ_LATENCY(2), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n),
        .rd_cnt(rd1), .wr_cnt(wr1), .lat_err(lat1)
    );

    sram_chip_model #(.DEPTH(16), .READ_LATENCY(0), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n[2]), .SRAM_OE_N(oe_n),
        .rd_cnt(rd2), .wr_cnt(wr2), .lat_err(lat2)
    );

    localparam logic [2:0] CA = 3'b110;
    localparam logic [2:0] CB = 3'b101;
    localparam logic [2:0] CC = 3'b011;
    localparam logic [2:0] CN = 3'b111;

    localparam int S_DQ  = 0;
    localparam int S_RD  = 1;
    localparam int S_WR  = 2;
    localparam int S_LAT = 3;

    typedef struct {
        int          cyc;
        int          sig;
        int          dut;
        logic [31:0] exp;
        bit          ne;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_act(input int sig, input int dut);
        logic [31:0] v;
        v = 32'h0;
        case (sig)
            S_DQ:  v = (dut == 0) ? {16'h0, dq0} :
                       (dut == 1) ? {16'h0, dq1} : {16'h0, dq2};
            S_RD:  v = (dut == 0) ? rd0 : (dut == 1) ? rd1 : {30'h0, rd2};
            S_WR:  v = (dut == 0) ? wr0 : (dut == 1) ? wr1 : {30'h0, wr2};
            default: v = (dut == 0) ? {31'h0, lat0} :
                         (dut == 1) ? {31'h0, lat1} : {31'h0, lat2};
        endcase
        return v;
    endfunction

    task automatic push(input string nm, input int sig, input int dut,
                        input logic [31:0] e, input bit ne);
        exp_t x;
        x.cyc  = cyc;
        x.sig  = sig;
        x.dut  = dut;
        x.exp  = e;
        x.ne   = ne;
        x.name = nm;
        q.push_back(x);
    endtask

    task automatic ex(input string nm, input int sig, input int dut,
                      input logic [31:0] e);
        push(nm, sig, dut, e, 1'b0);
    endtask

    task automatic drive(input logic [2:0] ce, input logic we, input logic oe,
                         input logic ub, input logic lb,
                         input logic [17:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        ce_n  = ce;
        we_n  = we;
        oe_n  = oe;
        ub_n  = ub;
        lb_n  = lb;
        addr  = a;
        tb_dq = d;
        tb_oe = !we;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e   = q.pop_front();
            m_act = get_act(m_e.sig, m_e.dut);
            n_cmp++;
            if (m_e.ne ? (m_act === m_e.exp) : (m_act !== m_e.exp)) begin
                n_bad++;
                $display("FAIL %s: got %h, want %s%h", m_e.name, m_act,
                         m_e.ne ? "not " : "", m_e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        ce_n  = CN;
        we_n  = 1'b1;
        oe_n  = 1'b1;
        ub_n  = 1'b0;
        lb_n  = 1'b0;
        addr  = '0;
        tb_oe = 1'b0;
        tb_dq = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ex("rst_rd0", S_RD, 0, 0);
        ex("rst_wr0", S_WR, 0, 0);
        ex("rst_lat0", S_LAT, 0, 0);
        ex("rst_dq0_z", S_DQ, 0, 32'hFFFF);
        ex("rst_rd2", S_RD, 2, 0);
        ex("rst_lat1", S_LAT, 1, 0);

        drive(CA, 0, 1, 0, 0, 18'h00010, 16'hBEEF);
        drive(CA, 0, 1, 0, 0, 18'h00011, 16'hCAFE);
        ex("wr_cnt_1", S_WR, 0, 1);
        drive(CA, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("rd_beef", S_DQ, 0, 32'hBEEF);
        ex("wr_cnt_2", S_WR, 0, 2);
        ex("rd_cnt_0", S_RD, 0, 0);
        drive(CA, 1, 0, 0, 0, 18'h00011, 16'h0);
        ex("rd_cafe", S_DQ, 0, 32'hCAFE);
        ex("rd_cnt_1", S_RD, 0, 1);
        drive(CA, 0, 1, 0, 0, 18'h00020, 16'h1234);
        ex("rd_cnt_2", S_RD, 0, 2);
        drive(CA, 0, 0, 1, 0, 18'h00020, 16'hABCD);
        ex("wr_cnt_3", S_WR, 0, 3);
        drive(CA, 1, 0, 0, 0, 18'h00020, 16'h0);
        ex("mask_12cd", S_DQ, 0, 32'h12CD);
        ex("wr_cnt_4", S_WR, 0, 4);
        drive(CA, 1, 0, 0, 1, 18'h00020, 16'h0);
        ex("lane_12zz", S_DQ, 0, 32'h12FF);
        ex("rd_cnt_3", S_RD, 0, 3);
        drive(CN, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("ce_off_z", S_DQ, 0, 32'hFFFF);
        ex("rd_cnt_4", S_RD, 0, 4);
        drive(CA, 1, 1, 0, 0, 18'h00010, 16'h0);
        ex("oe_off_z", S_DQ, 0, 32'hFFFF);
        ex("rd_cnt_ce", S_RD, 0, 4);
        drive(CA, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("rd_beef_2", S_DQ, 0, 32'hBEEF);
        ex("rd_cnt_oe", S_RD, 0, 4);
        drive(CA, 0, 1, 0, 0, 18'h00030, 16'h7777);
        rst = 1'b1;
        ex("pre_rst_rd", S_RD, 0, 5);
        ex("pre_rst_wr", S_WR, 0, 4);
        drive(CN, 1, 1, 0, 0, 18'h0, 16'h0);
        rst = 1'b0;
        ex("post_rst_rd", S_RD, 0, 0);
        ex("post_rst_wr", S_WR, 0, 0);
        ex("post_rst_lat", S_LAT, 0, 0);
        drive(CA, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("keep_beef", S_DQ, 0, 32'hBEEF);
        drive(CA, 1, 0, 0, 0, 18'h00030, 16'h0);
        ex("rst_cycle_wr", S_DQ, 0, 32'h7777);
        ex("rd_after_rst", S_RD, 0, 1);
        drive(CA, 0, 1, 1, 1, 18'h00010, 16'h0000);
        ex("rd_cnt_a2", S_RD, 0, 2);
        drive(CA, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("masked_wr_data", S_DQ, 0, 32'hBEEF);
        ex("masked_wr_cnt", S_WR, 0, 0);

        drive(CB, 0, 1, 0, 0, 18'h00010, 16'hBEEF);
        drive(CB, 1, 0, 0, 0, 18'h00010, 16'h0);
        push("lat_cyc0", S_DQ, 1, 32'hBEEF, 1'b1);
        ex("lat_wr_cnt", S_WR, 1, 1);
        drive(CB, 1, 0, 0, 0, 18'h00010, 16'h0);
        push("lat_cyc1", S_DQ, 1, 32'hBEEF, 1'b1);
        drive(CB, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("lat_cyc2", S_DQ, 1, 32'hBEEF);
        ex("lat_ok_0", S_LAT, 1, 0);
        drive(CB, 1, 0, 0, 0, 18'h00011, 16'h0);
        ex("lat_ok_1", S_LAT, 1, 0);
        drive(CB, 1, 0, 0, 0, 18'h00010, 16'h0);
        ex("lat_ok_2", S_LAT, 1, 0);
        push("lat_rearm", S_DQ, 1, 32'hBEEF, 1'b1);
        drive(CN, 1, 1, 0, 0, 18'h0, 16'h0);
        ex("lat_err_set", S_LAT, 1, 1);
        ex("lat_rd_cnt", S_RD, 1, 5);
        drive(CN, 1, 1, 0, 0, 18'h0, 16'h0);
        ex("lat_err_stick", S_LAT, 1, 1);

        drive(CC, 0, 1, 0, 0, 18'h00013, 16'h5555);
        drive(CC, 1, 0, 0, 0, 18'h00003, 16'h0);
        ex("wrap_rd", S_DQ, 2, 32'h5555);
        ex("wrap_wr_cnt", S_WR, 2, 1);
        ex("wrap_rd_cnt0", S_RD, 2, 0);
        drive(CC, 1, 0, 0, 0, 18'h00013, 16'h0);
        ex("wrap_rd_hi", S_DQ, 2, 32'h5555);
        ex("sat_rd_1", S_RD, 2, 1);
        drive(CC, 1, 0, 0, 0, 18'h00003, 16'h0);
        ex("sat_rd_2", S_RD, 2, 2);
        drive(CC, 1, 0, 0, 0, 18'h00003, 16'h0);
        ex("sat_rd_3", S_RD, 2, 3);
        drive(CC, 1, 0, 0, 0, 18'h00003, 16'h0);
        ex("sat_rd_hold", S_RD, 2, 3);
        drive(CN, 1, 1, 0, 0, 18'h0, 16'h0);
        ex("sat_rd_end", S_RD, 2, 3);

        drive(CN, 1, 1, 0, 0, 18'h0, 16'h0);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            m_e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unchecked, want checked", m_e.name);
        end
        n_cmp++;
        if (lat1 !== 1'b1) begin
            n_bad++;
            $display("FAIL end_lat1: got %b, want 1", lat1);
        end
        n_cmp++;
        if (rd2 !== 2'd3) begin
            n_bad++;
            $display("FAIL end_rd2: got %h, want 3", rd2);
        end
        n_cmp++;
        if (wr2 !== 2'd1) begin
            n_bad++;
            $display("FAIL end_wr2: got %h, want 1", wr2);
        end
        n_cmp++;
        if (lat0 !== 1'b0) begin
            n_bad++;
            $display("FAIL end_lat0: got %b, want 0", lat0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
